pb_debounce_array: RTL

Parametrised multi-channel push-button conditioner for the game's button matrix (one channel per mole hole plus start/reset keys). Each channel synchronises a raw asynchronous button input, applies a symmetric counter-based stability window to both press and release, and produces a clean level plus single-cycle press, release and long-press pulses. The game FSM and score logic consume these outputs directly. A shared sample strobe makes the window length independent of clk frequency.

---
 rtl/pb_debounce_array.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pb_debounce_array.sv
// Multi-channel push-button conditioner.
// Each channel synchronises a raw button input and accepts a new level only
// after the synchronised input has differed from the current level for
// STABLE_CNT consecutive sample ticks. It emits registered single-cycle
// press, release and long-press pulses. A glitch that returns to the current
// level before the window completes throws away all progress.
module pb_debounce_array #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int STABLE_CNT  = 4,
  parameter int LCNT_W      = 16,
  parameter int LONG_CNT    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_en,
  input  logic [CH-1:0] pb_in,
  output logic [CH-1:0] pb_level,
  output logic [CH-1:0] pb_press,
  output logic [CH-1:0] pb_release,
  output logic [CH-1:0] pb_long,
  output logic          pb_any
);

  // Last count value of the stability window; reaching it on a tick flips the level.
  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CNT - 1);
  // Long-press threshold and enable (LONG_CNT = 0 switches the feature off).
  localparam logic [LCNT_W-1:0] LONG_TGT    = LCNT_W'(LONG_CNT);
  localparam bit                LONG_EN     = (LONG_CNT != 0);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic [LCNT_W-1:0]      lcnt_q, lcnt_d;
    logic [LCNT_W-1:0]      lcnt_inc;
    logic                   long_q, long_d;

    // Shift the raw asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pb_in[g]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Stability window: clear on agreement, advance on mismatched ticks, flip level at the end.
    always_comb begin
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s == level_q) begin
        cnt_d = '0;
      end else if (tick_en) begin
        if (cnt_q == STABLE_LAST) begin
          cnt_d     = '0;
          level_d   = ~level_q;
          press_d   = ~level_q;
          release_d = level_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    assign lcnt_inc = lcnt_q + LCNT_W'(1);

    // Long-press timer: counts ticks while the accepted level is high, saturating at the threshold.
    always_comb begin
      lcnt_d = lcnt_q;
      long_d = 1'b0;
      if (!level_q) begin
        lcnt_d = '0;
      end else if (tick_en && LONG_EN && (lcnt_q != LONG_TGT)) begin
        lcnt_d = lcnt_inc;
        long_d = (lcnt_inc == LONG_TGT);
      end
    end

    // Register the window state, accepted level and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Register the long-press timer and its one-shot pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lcnt_q <= '0;
        long_q <= 1'b0;
      end else begin
        lcnt_q <= lcnt_d;
        long_q <= long_d;
      end
    end

    assign pb_level[g]   = level_q;
    assign pb_press[g]   = press_q;
    assign pb_release[g] = release_q;
    assign pb_long[g]    = long_q;
  end

  assign pb_any = |pb_level;

endmodule
